// File: rtl/zeroheti_obi_arbiter.sv
// N-manager to 1-subordinate OBI arbiter, round-robin with one bounded high-priority manager.
// Latency: address phase is combinational from IDLE; one transaction outstanding at a time.
// Backpressure: sbr_gnt_i low holds the latched owner in ADDR; responses route back to that owner.
module zeroheti_obi_arbiter #(
    parameter int unsigned NumMgr        = 3,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter bit          HiPrioEn      = 1'b1,
    parameter int unsigned HiPrioIdx     = 0,
    parameter int unsigned HiPrioMaxCons = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumMgr-1:0]                 mgr_req_i,
    input  logic [NumMgr*AddrWidth-1:0]       mgr_addr_i,
    input  logic [NumMgr-1:0]                 mgr_we_i,
    input  logic [NumMgr*(DataWidth/8)-1:0]   mgr_be_i,
    input  logic [NumMgr*DataWidth-1:0]       mgr_wdata_i,
    output logic [NumMgr-1:0]                 mgr_gnt_o,
    output logic [NumMgr-1:0]                 mgr_rvalid_o,
    output logic [DataWidth-1:0]              mgr_rdata_o,
    output logic                              mgr_err_o,
    output logic                              sbr_req_o,
    output logic [AddrWidth-1:0]              sbr_addr_o,
    output logic                              sbr_we_o,
    output logic [DataWidth/8-1:0]            sbr_be_o,
    output logic [DataWidth-1:0]              sbr_wdata_o,
    input  logic                              sbr_gnt_i,
    input  logic                              sbr_rvalid_i,
    input  logic [DataWidth-1:0]              sbr_rdata_i,
    input  logic                              sbr_err_i,
    output logic [$clog2(NumMgr)-1:0]         owner_o,
    output logic                              busy_o,
    output logic                              proto_err_o
);

    localparam int unsigned IdxW    = $clog2(NumMgr);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned CntW    = $clog2(HiPrioMaxCons + 1);
    localparam logic [IdxW-1:0] HpIdx  = IdxW'(HiPrioIdx);
    localparam logic [CntW-1:0] CntMax = CntW'(HiPrioMaxCons);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, rr_ptr_q;
    logic [CntW-1:0]   hp_cnt_q;
    logic              rr_sel_q, hp_inc_q;
    logic [IdxW-1:0]   win_idx, rr_idx, sel_idx;
    logic [NumMgr-1:0] hp_mask, rr_req;
    logic              others_req, hp_sat, hp_win, win_inc, rr_found;
    logic              grant, use_rr, use_inc;

    assign hp_mask    = NumMgr'(1) << HiPrioIdx;
    assign others_req = |(mgr_req_i & ~hp_mask);
    assign hp_sat     = (hp_cnt_q >= CntMax);
    assign hp_win     = HiPrioEn && mgr_req_i[HiPrioIdx] && !hp_sat;
    // A saturated hi-prio manager steps aside only while someone else is waiting.
    assign rr_req     = (HiPrioEn && hp_sat && others_req) ? (mgr_req_i & ~hp_mask) : mgr_req_i;

    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int unsigned k = 1; k <= NumMgr; k++) begin
            if (!rr_found && rr_req[(int'(rr_ptr_q) + k) % NumMgr]) begin
                rr_found = 1'b1;
                rr_idx   = IdxW'((int'(rr_ptr_q) + k) % NumMgr);
            end
        end
    end

    assign win_idx = hp_win ? HpIdx : rr_idx;
    assign win_inc = (win_idx == HpIdx) && others_req;

    always_comb begin
        state_d      = state_q;
        sbr_req_o    = 1'b0;
        sel_idx      = owner_q;
        mgr_gnt_o    = '0;
        mgr_rvalid_o = '0;
        case (state_q)
            IDLE: begin
                if (|mgr_req_i) begin
                    sbr_req_o = 1'b1;
                    sel_idx   = win_idx;
                    if (sbr_gnt_i) begin
                        mgr_gnt_o[win_idx] = 1'b1;
                        state_d            = RESP;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (mgr_req_i[owner_q]) begin
                    sbr_req_o          = 1'b1;
                    mgr_gnt_o[owner_q] = sbr_gnt_i;
                    if (sbr_gnt_i) state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (sbr_rvalid_i) begin
                    mgr_rvalid_o[owner_q] = 1'b1;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant   = |mgr_gnt_o;
    // Arbitration flags are captured at selection so a delayed grant updates counters consistently.
    assign use_rr  = (state_q == IDLE) ? !hp_win : rr_sel_q;
    assign use_inc = (state_q == IDLE) ? win_inc : hp_inc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= IdxW'(NumMgr - 1);
            hp_cnt_q <= '0;
            rr_sel_q <= 1'b0;
            hp_inc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |mgr_req_i) begin
                owner_q  <= win_idx;
                rr_sel_q <= !hp_win;
                hp_inc_q <= win_inc;
            end
            if (grant) begin
                if (use_rr) rr_ptr_q <= sel_idx;
                if (!use_inc)    hp_cnt_q <= '0;
                else if (!hp_sat) hp_cnt_q <= hp_cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        sbr_addr_o  = '0;
        sbr_we_o    = 1'b0;
        sbr_be_o    = '0;
        sbr_wdata_o = '0;
        if (sbr_req_o) begin
            sbr_addr_o  = mgr_addr_i[int'(sel_idx)*AddrWidth +: AddrWidth];
            sbr_we_o    = mgr_we_i[sel_idx];
            sbr_be_o    = mgr_be_i[int'(sel_idx)*BeWidth +: BeWidth];
            sbr_wdata_o = mgr_wdata_i[int'(sel_idx)*DataWidth +: DataWidth];
        end
    end

    assign mgr_rdata_o = (state_q == RESP && sbr_rvalid_i) ? sbr_rdata_i : '0;
    assign mgr_err_o   = (state_q == RESP) && sbr_rvalid_i && sbr_err_i;
    assign proto_err_o = sbr_rvalid_i && (state_q != RESP);
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
// Directed scenarios plus randomized traffic checked against a rule-level arbitration model.
module tb_zeroheti_obi_arbiter;

    localparam int MaxCons = 4;

    logic        clk_i, rst_ni;
    logic [2:0]  mgr_req_i, mgr_we_i;
    logic [95:0] mgr_addr_i, mgr_wdata_i;
    logic [11:0] mgr_be_i;
    logic [2:0]  mgr_gnt_o, mgr_rvalid_o;
    logic [31:0] mgr_rdata_o;
    logic        mgr_err_o, sbr_req_o, sbr_we_o;
    logic [31:0] sbr_addr_o, sbr_wdata_o;
    logic [3:0]  sbr_be_o;
    logic        sbr_gnt_i, sbr_rvalid_i, sbr_err_i;
    logic [31:0] sbr_rdata_i;
    logic [1:0]  owner_o;
    logic        busy_o, proto_err_o;

    logic [31:0] m_addr[3];
    logic [31:0] m_wdata[3];
    logic [3:0]  m_be[3];
    assign mgr_addr_i  = {m_addr[2], m_addr[1], m_addr[0]};
    assign mgr_wdata_i = {m_wdata[2], m_wdata[1], m_wdata[0]};
    assign mgr_be_i    = {m_be[2], m_be[1], m_be[0]};

    zeroheti_obi_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
        .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
        .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o),
        .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
        .sbr_req_o(sbr_req_o), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
        .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
        .sbr_gnt_i(sbr_gnt_i), .sbr_rvalid_i(sbr_rvalid_i),
        .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i),
        .owner_o(owner_o), .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int gseq[$];
    int gcyc[$];

    // reference model state (spec-level)
    int rr_last, hp_cnt, exp_owner, resp_owner, lock_owner, w;
    bit resp_pend, locked, lock_rr, lock_inc, by_rr, inc, exp_req;
    bit pending[3];
    bit waiting[3];
    logic [2:0] req, exp_gnt, exp_rv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        mgr_req_i = '0; mgr_we_i = '0;
        sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0; sbr_err_i = 1'b0; sbr_rdata_i = '0;
        for (int i = 0; i < 3; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Always-granting subordinate answering one cycle after each grant; records grant order.
    task automatic run_cont(input logic [2:0] r, input int n);
        bit rv_next;
        rv_next = 1'b0;
        gseq.delete();
        gcyc.delete();
        for (int c = 0; c < 80 && gseq.size() < n; c++) begin
            mgr_req_i = r; sbr_gnt_i = 1'b1; sbr_rvalid_i = rv_next;
            #2;
            rv_next = |mgr_gnt_o;
            for (int i = 0; i < 3; i++) if (mgr_gnt_o[i]) begin gseq.push_back(i); gcyc.push_back(c); end
            cyc();
        end
        mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = rv_next;
        cyc();
        sbr_rvalid_i = 1'b0;
        check("cont_count", 64'(gseq.size()), 64'(n));
    endtask

    task automatic model_pick(input logic [2:0] r, output int win, output bit rr, output bit incr);
        bit others;
        logic [2:0] cand;
        others = r[1] | r[2];
        win = 0; rr = 1'b0;
        if (r[0] && hp_cnt < MaxCons) begin
            win = 0;
        end else begin
            rr = 1'b1;
            cand = r;
            if (hp_cnt >= MaxCons && others) cand[0] = 1'b0;
            for (int k = 3; k >= 1; k--) if (cand[(rr_last + k) % 3]) win = (rr_last + k) % 3;
        end
        incr = (win == 0) && others;
    endtask

    initial begin
        int exp_order[10];
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};

        // reset state
        do_reset();
        #2;
        check("rst_gnt", mgr_gnt_o, 0);
        check("rst_rvalid", mgr_rvalid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_sbr_req", sbr_req_o, 0);
        check("rst_owner", owner_o, 0);
        check("rst_proto", proto_err_o, 0);
        cyc();

        // single read, same-cycle grant
        mgr_req_i = 3'b010; m_addr[1] = 32'h100; sbr_gnt_i = 1'b1;
        #2;
        check("t1_gnt", mgr_gnt_o, 3'b010);
        check("t1_sbr_req", sbr_req_o, 1);
        check("t1_addr", sbr_addr_o, 32'h100);
        cyc();
        mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'hCAFE;
        #2;
        check("t1_rvalid", mgr_rvalid_o, 3'b010);
        check("t1_rdata", mgr_rdata_o, 32'hCAFE);
        check("t1_busy_resp", busy_o, 1);
        cyc();
        sbr_rvalid_i = 1'b0;
        #2;
        check("t1_busy_idle", busy_o, 0);
        check("t1_owner", owner_o, 1);

        // two-manager round robin
        do_reset();
        run_cont(3'b110, 4);
        for (int i = 0; i < 4 && i < gseq.size(); i++) check("t2_order", 64'(gseq[i]), 64'(1 + (i % 2)));
        for (int i = 1; i < 4 && i < gcyc.size(); i++) check("t2_interval", 64'(gcyc[i] - gcyc[i-1]), 2);

        // hi-prio bounded against starvation
        do_reset();
        run_cont(3'b111, 10);
        for (int i = 0; i < 10 && i < gseq.size(); i++) check("t3_order", 64'(gseq[i]), 64'(exp_order[i]));

        // delayed subordinate grant
        do_reset();
        mgr_req_i = 3'b100; m_addr[2] = 32'h2A0;
        for (int c = 0; c < 5; c++) begin
            #2;
            check("t4_addr_stable", sbr_addr_o, 32'h2A0);
            check("t4_no_gnt", mgr_gnt_o, 0);
            cyc();
        end
        sbr_gnt_i = 1'b1;
        #2;
        check("t4_gnt", mgr_gnt_o, 3'b100);
        cyc();
        mgr_req_i = '0; sbr_gnt_i = 1'b0;
        #2;
        check("t4_single_gnt", mgr_gnt_o, 0);
        cyc();
        sbr_rvalid_i = 1'b1;
        #2;
        check("t4_rvalid", mgr_rvalid_o, 3'b100);
        cyc();
        sbr_rvalid_i = 1'b0;

        // write with error response, then spurious rvalid
        mgr_req_i = 3'b100; mgr_we_i = 3'b100; m_be[2] = 4'hF; m_wdata[2] = 32'h1234; sbr_gnt_i = 1'b1;
        #2;
        check("t5_we", sbr_we_o, 1);
        check("t5_wdata", sbr_wdata_o, 32'h1234);
        check("t5_be", sbr_be_o, 4'hF);
        cyc();
        mgr_req_i = '0; mgr_we_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b1; sbr_err_i = 1'b1;
        #2;
        check("t5_rvalid", mgr_rvalid_o, 3'b100);
        check("t5_err", mgr_err_o, 1);
        cyc();
        sbr_rvalid_i = 1'b0;
        #2;
        check("t5_err_unqual", mgr_err_o, 0);
        cyc();
        sbr_err_i = 1'b0; sbr_rvalid_i = 1'b1;
        #2;
        check("t5_proto", proto_err_o, 1);
        check("t5_spur_rvalid", mgr_rvalid_o, 0);
        cyc();
        sbr_rvalid_i = 1'b0;
        #2;
        check("t5_proto_pulse", proto_err_o, 0);

        // owner withdraws request while waiting for grant
        cyc();
        mgr_req_i = 3'b001;
        #2;
        check("drop_req", sbr_req_o, 1);
        cyc();
        mgr_req_i = '0; sbr_gnt_i = 1'b1;
        #2;
        check("drop_sbr_req", sbr_req_o, 0);
        check("drop_gnt", mgr_gnt_o, 0);
        cyc();
        sbr_gnt_i = 1'b0;
        #2;
        check("drop_idle", busy_o, 0);

        // reset while a response is outstanding
        cyc();
        mgr_req_i = 3'b001; sbr_gnt_i = 1'b1;
        cyc();
        mgr_req_i = '0; sbr_gnt_i = 1'b0;
        #2;
        check("t6_in_resp", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_owner", owner_o, 0);
        check("t6_rst_rvalid", mgr_rvalid_o, 0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        cyc();
        sbr_rvalid_i = 1'b1; sbr_rdata_i = 32'hDEAD;
        #2;
        check("t6_late_proto", proto_err_o, 1);
        check("t6_late_rvalid", mgr_rvalid_o, 0);
        cyc();

        // randomized traffic vs model
        do_reset();
        rr_last = 2; hp_cnt = 0; exp_owner = 0; resp_pend = 0; locked = 0;
        resp_owner = 0; lock_owner = 0; lock_rr = 0; lock_inc = 0;
        for (int i = 0; i < 3; i++) begin pending[i] = 0; waiting[i] = 0; end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pending[i] && !waiting[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    m_addr[i] = $urandom; m_wdata[i] = $urandom;
                    m_be[i] = 4'($urandom); mgr_we_i[i] = 1'($urandom);
                end
            end
            req = {pending[2], pending[1], pending[0]};
            mgr_req_i = req;
            sbr_gnt_i = 1'($urandom);
            sbr_rvalid_i = resp_pend ? 1'($urandom) : ($urandom_range(0, 15) == 0);
            sbr_rdata_i = $urandom; sbr_err_i = 1'($urandom);

            exp_gnt = '0; exp_rv = '0; exp_req = 1'b0; w = 0; by_rr = 1'b0; inc = 1'b0;
            if (resp_pend) begin
                if (sbr_rvalid_i) exp_rv[resp_owner] = 1'b1;
            end else if (locked) begin
                exp_req = 1'b1; w = lock_owner; by_rr = lock_rr; inc = lock_inc;
            end else if (|req) begin
                exp_req = 1'b1;
                model_pick(req, w, by_rr, inc);
            end
            if (exp_req && sbr_gnt_i) exp_gnt[w] = 1'b1;

            #2;
            check("rnd_gnt", mgr_gnt_o, exp_gnt);
            check("rnd_rvalid", mgr_rvalid_o, exp_rv);
            check("rnd_rdata", mgr_rdata_o, (|exp_rv) ? sbr_rdata_i : 32'h0);
            check("rnd_err", mgr_err_o, (|exp_rv) & sbr_err_i);
            check("rnd_sbr_req", sbr_req_o, exp_req);
            check("rnd_addr", sbr_addr_o, exp_req ? m_addr[w] : 32'h0);
            check("rnd_wdata", sbr_wdata_o, exp_req ? m_wdata[w] : 32'h0);
            check("rnd_we", sbr_we_o, exp_req ? mgr_we_i[w] : 1'b0);
            check("rnd_proto", proto_err_o, sbr_rvalid_i & !resp_pend);
            check("rnd_busy", busy_o, resp_pend | locked);
            check("rnd_owner", owner_o, 64'(exp_owner));

            if (resp_pend) begin
                if (sbr_rvalid_i) begin resp_pend = 1'b0; waiting[resp_owner] = 1'b0; end
            end else if (exp_req) begin
                exp_owner = w;
                if (sbr_gnt_i) begin
                    pending[w] = 1'b0; waiting[w] = 1'b1;
                    resp_pend = 1'b1; resp_owner = w; locked = 1'b0;
                    if (by_rr) rr_last = w;
                    if (inc) hp_cnt = (hp_cnt < MaxCons) ? hp_cnt + 1 : MaxCons;
                    else     hp_cnt = 0;
                end else if (!locked) begin
                    locked = 1'b1; lock_owner = w; lock_rr = by_rr; lock_inc = inc;
                end
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
